prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Program-memory responder for the 14-bit-instruction core: the memory end of the prog_adr/prog_dat fetch interface.
- The core drives an instruction address; this block returns the instruction word with a fixed 1-cycle registered latency.
- A valid/ready load port lets the boot/debug loader write program words. The core is stalled while the block clears or loads memory.

Parameters:
ADR_W, 13, fetch/load address width
DAT_W, 14, instruction word width
DEPTH, 8192, implemented words (1 to 2**ADR_W)
NOP_WORD, 14'h0000, value returned when no valid word exists

Ports:
clk_i  in  1  system clock, rising edge
pon_rst_n_i  in  1  async active-low power-on reset
prog_adr_i  in  ADR_W  fetch address from core
prog_dat_o  out  DAT_W  fetched instruction, registered
prog_stall_o  out  1  core must hold PC while 1
load_req_i  in  1  loader requests LOAD mode (level)
ld_valid_i  in  1  load word valid
ld_ready_o  out  1  load word accepted when valid&ready
ld_adr_i  in  ADR_W  load address
ld_dat_i  in  DAT_W  load data
adr_err_o  out  1  sticky: fetch or load address >= DEPTH
par_err_o  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset is asynchronous on pon_rst_n_i low:
  - State becomes CLEAR and clr_cnt becomes 0.
  - prog_dat_o=NOP_WORD, prog_stall_o=1, ld_ready_o=0, adr_err_o=0, par_err_o=0.
  - Memory contents are not reset directly; CLEAR overwrites them.
- CLEAR state:
  - Each cycle writes NOP_WORD to mem[clr_cnt], then increments clr_cnt.
  - After writing DEPTH-1, moves to RUN. CLEAR takes exactly DEPTH cycles.
  - prog_stall_o=1 and prog_dat_o=NOP_WORD throughout.
  - load_req_i is ignored until CLEAR finishes.
- RUN state:
  - prog_stall_o=0, ld_ready_o=0.
  - Each cycle: prog_dat_o <= mem[prog_adr_i] if prog_adr_i < DEPTH, else NOP_WORD and adr_err_o <= 1.
  - Latency is 1 cycle: the address presented at edge N appears on prog_dat_o after edge N+1.
  - load_req_i=1 moves to LOAD at the next edge. The fetch issued in that same cycle still completes.
- LOAD state:
  - prog_stall_o=1, ld_ready_o=1, prog_dat_o holds its last value.
  - ld_valid_i&ld_ready_o writes mem[ld_adr_i] <= ld_dat_i.
  - ld_adr_i >= DEPTH: the write is dropped and adr_err_o <= 1; the handshake still completes.
  - load_req_i=0 returns to RUN at the next edge. A beat accepted in that same cycle is still written.
  - On re-entry to RUN, the first fetch reflects all loaded words (write-before-read ordering).
- Reset mid-CLEAR or mid-LOAD: restarts CLEAR from 0. Partially loaded data is lost.
- adr_err_o and par_err_o clear only on reset.
- No simultaneous fetch and load write is possible: the two are separated by state.

Optional Feature:
- Macro: PROG_PARITY_EN.
- Defined:
  - Memory is DAT_W+1 bits wide. Each write (CLEAR or LOAD) stores the even parity of the data word.
  - Each RUN fetch from an in-range address recomputes parity. On mismatch, par_err_o <= 1 and prog_dat_o <= NOP_WORD for that fetch.
- Undefined:
  - Memory is DAT_W bits wide and no parity logic exists.
  - par_err_o is tied 0.

Test Plan:
- Reset then hold 8192 cycles -> prog_stall_o=1 for exactly 8192 cycles after reset release, then 0. Fetch of 0x0005 returns 14'h0000.
- LOAD 14'h3FFF to 0x0000 and 14'h2805 to 0x0001, drop load_req_i, fetch 0x0000 then 0x0001 -> prog_dat_o=14'h3FFF, then 14'h2805 one cycle later.
- DEPTH=4096, fetch 0x1000 -> prog_dat_o=14'h0000 and adr_err_o=1. adr_err_o stays 1 after later valid fetches.
- load_req_i asserted during CLEAR -> ld_ready_o stays 0 until CLEAR ends, then 1 one cycle later.
- Pulse pon_rst_n_i low mid-LOAD after writing 0x0010=14'h1234 -> after CLEAR, fetch 0x0010 returns 14'h0000.
- With PROG_PARITY_EN, force a stored parity bit flip at 0x0002 and fetch it -> prog_dat_o=14'h0000 and par_err_o=1.

Source files
------------

// File: rtl/prog_mem_responder.sv
// prog_mem_responder: program memory answering the core's prog_adr/prog_dat fetch port.
// Latency: 1 cycle address-to-data (registered output); CLEAR lasts DEPTH cycles after reset.
// Backpressure: core is stalled (prog_stall_o) during CLEAR and LOAD; loader sees ld_ready_o only in LOAD.
//
// Optional build macro: PROG_PARITY_EN
//   defined   -> memory is DAT_W+1 wide; each stored word carries its even parity bit and
//                every in-range fetch is checked; a bad word returns NOP_WORD and sets par_err_o.
//   undefined -> memory is DAT_W wide, no parity logic, par_err_o tied 0.
//
// Ports:
//   clk_i         system clock, rising edge
//   pon_rst_n_i   async active-low power-on reset
//   prog_adr_i    fetch address from the core
//   prog_dat_o    fetched instruction (registered)
//   prog_stall_o  core must hold its PC while high
//   load_req_i    loader requests LOAD mode (level)
//   ld_valid_i    load beat valid
//   ld_ready_o    load beat accepted when ld_valid_i & ld_ready_o
//   ld_adr_i      load address
//   ld_dat_i      load data
//   adr_err_o     sticky: fetch or load address >= DEPTH
//   par_err_o     sticky: parity mismatch on fetch (parity build only)

module prog_mem_responder #(
   parameter int unsigned       ADR_W    = 13,
   parameter int unsigned       DAT_W    = 14,
   parameter int unsigned       DEPTH    = 8192,
   parameter logic [DAT_W-1:0]  NOP_WORD = '0
) (
   input  logic              clk_i,
   input  logic              pon_rst_n_i,
   input  logic [ADR_W-1:0]  prog_adr_i,
   output logic [DAT_W-1:0]  prog_dat_o,
   output logic              prog_stall_o,
   input  logic              load_req_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADR_W-1:0]  ld_adr_i,
   input  logic [DAT_W-1:0]  ld_dat_i,
   output logic              adr_err_o,
   output logic              par_err_o
);

`ifdef PROG_PARITY_EN
   localparam int unsigned MEM_W = DAT_W + 1;
`else
   localparam int unsigned MEM_W = DAT_W;
`endif

   // Memory index width: enough bits for DEPTH entries (at least one bit).
   localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
   // DEPTH widened by one bit so DEPTH == 2**ADR_W still compares correctly.
   localparam logic [ADR_W:0]    DEPTH_EXT = (ADR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------
   state_t              state_q, state_d;
   logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
   logic [DAT_W-1:0]    prog_dat_q, prog_dat_d;
   logic                adr_err_q, adr_err_d;

   // Contents are not reset: the CLEAR sweep initialises every word.
   logic [MEM_W-1:0]    mem_q [DEPTH];

   // Single write port shared by the CLEAR sweep and loader beats;
   // the state machine guarantees they never collide.
   logic                mem_we;
   logic [IDX_W-1:0]    mem_wadr;
   logic [DAT_W-1:0]    mem_wdat;
   logic [MEM_W-1:0]    mem_wword;

   logic                fetch_in_rng;
   logic                ld_in_rng;
   logic [MEM_W-1:0]    rd_word;

   assign fetch_in_rng = ({1'b0, prog_adr_i} < DEPTH_EXT);
   assign ld_in_rng    = ({1'b0, ld_adr_i}   < DEPTH_EXT);

   // Upper address bits are zero whenever the address is in range, so the
   // truncated index only matters on reads that are discarded anyway.
   assign rd_word = mem_q[prog_adr_i[IDX_W-1:0]];

`ifdef PROG_PARITY_EN
   logic par_err_q, par_err_d;
   logic rd_par_bad;

   // Even parity: data bits plus stored parity bit must XOR to zero.
   assign mem_wword  = {^mem_wdat, mem_wdat};
   assign rd_par_bad = ^rd_word;
`else
   assign mem_wword  = mem_wdat;
`endif

   // ---------------------------------------------------------------
   // Next-state / datapath control
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      prog_dat_d = prog_dat_q;
      adr_err_d  = adr_err_q;
`ifdef PROG_PARITY_EN
      par_err_d  = par_err_q;
`endif
      mem_we     = 1'b0;
      mem_wadr   = clr_cnt_q;
      mem_wdat   = NOP_WORD;

      case (state_q)
         ST_CLEAR: begin
            // Sweep NOP_WORD through every word; load_req_i is not looked at.
            mem_we     = 1'b1;
            prog_dat_d = NOP_WORD;
            if (clr_cnt_q == LAST_IDX) begin
               state_d = ST_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + IDX_W'(1);
            end
         end

         ST_RUN: begin
            // The fetch of this cycle completes even if we leave for LOAD.
            if (fetch_in_rng) begin
`ifdef PROG_PARITY_EN
               if (rd_par_bad) begin
                  prog_dat_d = NOP_WORD;
                  par_err_d  = 1'b1;
               end else begin
                  prog_dat_d = rd_word[DAT_W-1:0];
               end
`else
               prog_dat_d = rd_word;
`endif
            end else begin
               prog_dat_d = NOP_WORD;
               adr_err_d  = 1'b1;
            end
            if (load_req_i) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // ld_ready_o is high for the whole state, so a valid beat is
            // always accepted; out-of-range beats complete but are dropped.
            // A beat in the exit cycle is still written, and since the
            // write lands on the same edge that returns to RUN, the first
            // fetch afterwards sees it.
            if (ld_valid_i) begin
               if (ld_in_rng) begin
                  mem_we   = 1'b1;
                  mem_wadr = ld_adr_i[IDX_W-1:0];
                  mem_wdat = ld_dat_i;
               end else begin
                  adr_err_d = 1'b1;
               end
            end
            if (!load_req_i) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
      if (!pon_rst_n_i) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         prog_dat_q <= NOP_WORD;
         adr_err_q  <= 1'b0;
`ifdef PROG_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         prog_dat_q <= prog_dat_d;
         adr_err_q  <= adr_err_d;
`ifdef PROG_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[mem_wadr] <= mem_wword;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign prog_dat_o   = prog_dat_q;
   assign prog_stall_o = (state_q != ST_RUN);
   assign ld_ready_o   = (state_q == ST_LOAD);
   assign adr_err_o    = adr_err_q;
`ifdef PROG_PARITY_EN
   assign par_err_o    = par_err_q;
`else
   assign par_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Testbench for prog_mem_responder: directed scenarios plus randomized traffic,
// scored against a behavioural model of the fetch/load protocol.
// A 4096-word instance is used so out-of-range addresses exist on a 13-bit bus.

module tb_prog_mem_responder;

   localparam int          ADR_W = 13;
   localparam int          DAT_W = 14;
   localparam int          DEPTH = 4096;
   localparam logic [13:0] NOP   = 14'h0000;
   localparam int          LIM   = DEPTH + 64;

   localparam int M_CLEAR = 0;
   localparam int M_RUN   = 1;
   localparam int M_LOAD  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADR_W-1:0]  prog_adr;
   logic [DAT_W-1:0]  prog_dat;
   logic              prog_stall;
   logic              load_req;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADR_W-1:0]  ld_adr;
   logic [DAT_W-1:0]  ld_dat;
   logic              adr_err;
   logic              par_err;

   prog_mem_responder #(
      .ADR_W    (ADR_W),
      .DAT_W    (DAT_W),
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP)
   ) dut (
      .clk_i        (clk),
      .pon_rst_n_i  (rst_n),
      .prog_adr_i   (prog_adr),
      .prog_dat_o   (prog_dat),
      .prog_stall_o (prog_stall),
      .load_req_i   (load_req),
      .ld_valid_i   (ld_valid),
      .ld_ready_o   (ld_ready),
      .ld_adr_i     (ld_adr),
      .ld_dat_i     (ld_dat),
      .adr_err_o    (adr_err),
      .par_err_o    (par_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: memory as a sparse map (absent = NOP after CLEAR),
   // mode and countdown of the CLEAR sweep, sticky error flags.
   // ------------------------------------------------------------------
   int               m_mode      = M_CLEAR;
   int               m_clr_left  = DEPTH;
   bit               m_adr_err   = 1'b0;
   bit               m_par_err   = 1'b0;
   logic [13:0]      m_mem [int];
   bit               m_bad [int];
   logic [13:0]      exp_q [$];

   function automatic logic [13:0] m_read(input int a);
      if (m_mem.exists(a)) return m_mem[a];
      return NOP;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode     = M_CLEAR;
         m_clr_left = DEPTH;
         m_adr_err  = 1'b0;
         m_par_err  = 1'b0;
         m_mem.delete();
         m_bad.delete();
      end else begin
         case (m_mode)
            M_CLEAR: begin
               m_clr_left--;
               if (m_clr_left == 0) m_mode = M_RUN;
            end
            M_RUN: begin
               if (int'(prog_adr) >= DEPTH) begin
                  exp_q.push_back(NOP);
                  m_adr_err = 1'b1;
               end else if (m_bad.exists(int'(prog_adr))) begin
                  exp_q.push_back(NOP);
                  m_par_err = 1'b1;
               end else begin
                  exp_q.push_back(m_read(int'(prog_adr)));
               end
               if (load_req) m_mode = M_LOAD;
            end
            default: begin
               if (ld_valid) begin
                  if (int'(ld_adr) < DEPTH) begin
                     m_mem[int'(ld_adr)] = ld_dat;
                     if (m_bad.exists(int'(ld_adr))) m_bad.delete(int'(ld_adr));
                  end else begin
                     m_adr_err = 1'b1;
                  end
               end
               if (!load_req) m_mode = M_RUN;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Monitor: a response is presented after every edge at which the DUT
   // was not stalling; otherwise the output must hold its previous value.
   // ------------------------------------------------------------------
   logic        stall_pre = 1'b1;
   int          rd_ptr    = 0;
   logic [13:0] last_dat  = NOP;

   always @(negedge clk) stall_pre = prog_stall;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rd_ptr   = exp_q.size();
            last_dat = NOP;
            chk("rst_dat", 32'(prog_dat), 32'(NOP));
         end else if (!stall_pre) begin
            if (rd_ptr < exp_q.size()) begin
               chk("fetch_dat", 32'(prog_dat), 32'(exp_q[rd_ptr]));
               last_dat = exp_q[rd_ptr];
               rd_ptr++;
            end else begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_resp: actual %0h required none (t=%0t)", prog_dat, $time);
            end
         end else begin
            chk("hold_dat", 32'(prog_dat), 32'(last_dat));
         end
         chk("stall",   32'(prog_stall), 32'(m_mode != M_RUN));
         chk("ready",   32'(ld_ready),   32'(m_mode == M_LOAD));
         chk("adr_err", 32'(adr_err),    32'(m_adr_err));
         chk("par_err", 32'(par_err),    32'(m_par_err));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rand_phase(input int cycles, input bit allow_oor);
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 7) == 0) load_req = ~load_req;
         ld_valid = 1'($urandom_range(0, 1));
         ld_dat   = 14'($urandom);
         ld_adr   = 13'($urandom_range(0, 31));
         prog_adr = 13'($urandom_range(0, 31));
         if (allow_oor && $urandom_range(0, 7) == 0) ld_adr   = 13'($urandom_range(DEPTH, 8191));
         if (allow_oor && $urandom_range(0, 7) == 0) prog_adr = 13'($urandom_range(DEPTH, 8191));
         tick();
      end
      load_req = 1'b0;
      ld_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      prog_adr = '0;
      load_req = 1'b0;
      ld_valid = 1'b0;
      ld_adr   = '0;
      ld_dat   = '0;
      repeat (3) tick();
      rst_n = 1'b1;

      // CLEAR length: stall high for exactly DEPTH samples after release.
      n = 0;
      while (prog_stall && n < LIM) begin
         n++;
         tick();
      end
      chk("clear_len", 32'(n), 32'(DEPTH));

      // Cleared memory reads NOP; last in-range word is not an error.
      prog_adr = 13'h0005; tick();
      prog_adr = 13'h0FFF; tick();

      // Two loader beats, second one in the exit cycle, then read back.
      load_req = 1'b1; tick();
      ld_valid = 1'b1; ld_adr = 13'h0000; ld_dat = 14'h3FFF; tick();
      ld_adr = 13'h0001; ld_dat = 14'h2805; load_req = 1'b0; tick();
      ld_valid = 1'b0;
      prog_adr = 13'h0000; tick();
      prog_adr = 13'h0001; tick();

      rand_phase(400, 1'b0);

      // First out-of-range fetch; flag must stay set afterwards.
      prog_adr = 13'h1000; tick();
      prog_adr = 13'h0000; tick();
      prog_adr = 13'h0001; tick();

      // Reset in the middle of LOAD with load_req held high throughout.
      load_req = 1'b1; tick();
      ld_valid = 1'b1; ld_adr = 13'h0010; ld_dat = 14'h1234; tick();
      ld_valid = 1'b0;
      #3 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      n = 0;
      while (!ld_ready && n < LIM) begin
         n++;
         tick();
      end
      chk("ready_after_clear", 32'(n), 32'(DEPTH + 1));

      // Out-of-range load beat: handshake completes, write dropped.
      ld_valid = 1'b1; ld_adr = 13'h1000; ld_dat = 14'h0ABC; tick();
      ld_valid = 1'b0; load_req = 1'b0; tick();
      prog_adr = 13'h0010; tick();
      prog_adr = 13'h0000; tick();

`ifdef PROG_PARITY_EN
      load_req = 1'b1; tick();
      ld_valid = 1'b1; ld_adr = 13'h0002; ld_dat = 14'h1555; tick();
      ld_valid = 1'b0; load_req = 1'b0; tick();
      dut.mem_q[2] = dut.mem_q[2] ^ 15'h4000;
      m_bad[2] = 1'b1;
      prog_adr = 13'h0002; tick();
      prog_adr = 13'h0003; tick();
`endif

      rand_phase(400, 1'b1);

      chk("drain", 32'(rd_ptr), 32'(exp_q.size()));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
